// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: control FSM encoding and the
// stack-pointer reset constant.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALL_LO,
    RET_HI,
    RET_DONE
  } state_e;

  // The stack starts at the top word; each instance slices this to ADDR_W.
  localparam int unsigned MAX_ADDR_W = 32;
  localparam logic [MAX_ADDR_W-1:0] SP_RESET_ALL = '1;

endpackage

// File: rtl/data_memory.sv
// Single-port data RAM: synchronous write and registered read. The read
// register only updates on a read, so it holds the last value read.
module data_memory #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array and its read register have no reset; RAM macros provide
  // none, and the stage above masks the read register until the first read.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// Memory stage: load/store, full-descending stack and two-word call/return,
// all sharing the single data-memory port under a fixed request priority.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              push,
  input  logic              pop,
  input  logic              call,
  input  logic              ret,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic [31:0]       return_pc,
  output logic [DATA_W-1:0] read_data,
  output logic [31:0]       ret_pc,
  output logic              ret_valid,
  output logic              stall,
  output logic [ADDR_W-1:0] sp
);

  localparam logic [ADDR_W-1:0] SP_RESET = SP_RESET_ALL[ADDR_W-1:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [15:0]       pc_lo_q, pc_lo_d;
  logic [31:0]       ret_pc_q, ret_pc_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              rd_sel_q, rd_sel_d;

  logic              mem_we, mem_re, stall_req;
  logic [ADDR_W-1:0] mem_addr, sp_inc, sp_dec;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              unused_addr_hi;

  assign sp_inc = sp_q + ADDR_W'(1);
  assign sp_dec = sp_q - ADDR_W'(1);
  assign unused_addr_hi = ^address[DATA_W-1:ADDR_W];

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    pc_lo_d     = pc_lo_q;
    ret_pc_d    = ret_pc_q;
    rd_sel_d    = rd_sel_q;
    read_data_d = read_data;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = sp_q;
    mem_wdata   = write_data;
    stall_req   = 1'b0;
    ret_valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (call) begin
          mem_we    = 1'b1;
          mem_wdata = DATA_W'(return_pc[31:16]);
          pc_lo_d   = return_pc[15:0];
          sp_d      = sp_dec;
          stall_req = 1'b1;
          state_d   = CALL_LO;
        end else if (ret) begin
          // Return reads reuse the RAM read register, so park read_data.
          mem_re    = 1'b1;
          mem_addr  = sp_inc;
          sp_d      = sp_inc;
          rd_sel_d  = 1'b0;
          stall_req = 1'b1;
          state_d   = RET_HI;
        end else if (push) begin
          mem_we = 1'b1;
          sp_d   = sp_dec;
        end else if (pop) begin
          mem_re   = 1'b1;
          mem_addr = sp_inc;
          sp_d     = sp_inc;
          rd_sel_d = 1'b1;
        end else if (mem_write) begin
          mem_we   = 1'b1;
          mem_addr = address[ADDR_W-1:0];
        end else if (mem_read) begin
          mem_re   = 1'b1;
          mem_addr = address[ADDR_W-1:0];
          rd_sel_d = 1'b1;
        end
      end
      CALL_LO: begin
        mem_we    = 1'b1;
        mem_wdata = DATA_W'(pc_lo_q);
        sp_d      = sp_dec;
        state_d   = IDLE;
      end
      RET_HI: begin
        ret_pc_d[15:0] = mem_rdata[15:0];
        mem_re    = 1'b1;
        mem_addr  = sp_inc;
        sp_d      = sp_inc;
        stall_req = 1'b1;
        state_d   = RET_DONE;
      end
      RET_DONE: begin
        ret_pc_d[31:16] = mem_rdata[15:0];
        ret_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sp_q        <= SP_RESET;
      pc_lo_q     <= '0;
      ret_pc_q    <= '0;
      read_data_q <= '0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      pc_lo_q     <= pc_lo_d;
      ret_pc_q    <= ret_pc_d;
      read_data_q <= read_data_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  data_memory #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_data_memory (
    .clk   (clk),
    .we    (mem_we & rst_n),
    .re    (mem_re & rst_n),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // The high return half leaves the RAM in RET_DONE itself; after that it is held in ret_pc_q.
  assign read_data = rd_sel_q ? mem_rdata : read_data_q;
  assign ret_pc    = (state_q == RET_DONE) ? {mem_rdata[15:0], ret_pc_q[15:0]} : ret_pc_q;
  assign stall     = stall_req & rst_n;
  assign sp        = sp_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a word-array reference model queues
// expected results; a negedge monitor compares them with the DUT outputs.
module tb_memory_stage;

  localparam logic [5:0] Q_CALL = 6'b100000;
  localparam logic [5:0] Q_RET  = 6'b010000;
  localparam logic [5:0] Q_PUSH = 6'b001000;
  localparam logic [5:0] Q_POP  = 6'b000100;
  localparam logic [5:0] Q_WR   = 6'b000010;
  localparam logic [5:0] Q_RD   = 6'b000001;

  typedef struct { int cyc; logic stall; logic [10:0] sp; } cyc_exp_t;
  typedef struct { int due; logic [15:0] val; } rd_exp_t;
  typedef struct { int due; logic [31:0] pc; } ret_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, push, pop, call, ret;
  logic [15:0] address, write_data;
  logic [31:0] return_pc;
  logic [15:0] read_data;
  logic [31:0] ret_pc;
  logic        ret_valid, stall;
  logic [10:0] sp;

  memory_stage #(.ADDR_W(11), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .push(push), .pop(pop), .call(call), .ret(ret), .address(address),
    .write_data(write_data), .return_pc(return_pc), .read_data(read_data),
    .ret_pc(ret_pc), .ret_valid(ret_valid), .stall(stall), .sp(sp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;
  bit mon_en = 1'b0;

  cyc_exp_t    cyc_q[$];
  rd_exp_t     rd_q[$];
  ret_exp_t    ret_q[$];
  logic [15:0] exp_rd = '0;

  logic [15:0] m_mem   [2048];
  bit          m_known [2048];
  logic [10:0] m_sp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int top_req(input logic [5:0] req);
    int op = -1;
    for (int b = 5; b >= 0; b--) if (req[b] && op < 0) op = b;
    return op;
  endfunction

  // Drives one request (held for its whole stall window) and applies its
  // architectural effect to the reference model.
  task automatic issue(input logic [5:0] req, input logic [15:0] addr,
                       input logic [15:0] data, input logic [31:0] pc);
    int op, n, cyc0;
    logic [10:0] a, s1, s2, sm1;
    cyc_exp_t e;
    op  = top_req(req);
    a   = addr[10:0];
    s1  = m_sp + 11'd1;
    s2  = m_sp + 11'd2;
    sm1 = m_sp - 11'd1;
    n   = (op == 5) ? 2 : (op == 4) ? 3 : 1;
    cyc0 = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      {call, ret, push, pop, mem_write, mem_read} = req;
      address = addr; write_data = data; return_pc = pc;
      if (i == 0) cyc0 = cyc;
      e.cyc   = cyc;
      e.stall = (op == 5 && i == 0) || (op == 4 && i < 2);
      e.sp    = (op == 5) ? m_sp - 11'(i) : (op == 4) ? m_sp + 11'(i) : m_sp;
      cyc_q.push_back(e);
    end
    case (op)
      5: begin
        m_mem[m_sp] = pc[31:16]; m_known[m_sp] = 1'b1;
        m_mem[sm1]  = pc[15:0];  m_known[sm1]  = 1'b1;
        m_sp = m_sp - 11'd2;
      end
      4: begin
        ret_q.push_back('{cyc0 + 2, {m_mem[s2], m_mem[s1]}});
        m_sp = s2;
      end
      3: begin
        m_mem[m_sp] = data; m_known[m_sp] = 1'b1;
        m_sp = sm1;
      end
      2: begin
        rd_q.push_back('{cyc0 + 1, m_mem[s1]});
        m_sp = s1;
      end
      1: begin
        m_mem[a] = data; m_known[a] = 1'b1;
      end
      0: rd_q.push_back('{cyc0 + 1, m_mem[a]});
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
        cyc_exp_t e;
        e = cyc_q.pop_front();
        check("stall", {31'd0, stall}, {31'd0, e.stall});
        check("sp", {21'd0, sp}, {21'd0, e.sp});
      end
      while (rd_q.size() > 0 && rd_q[0].due <= cyc) exp_rd = rd_q.pop_front().val;
      check("read_data", {16'd0, read_data}, {16'd0, exp_rd});
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        ret_exp_t r;
        r = ret_q.pop_front();
        check("ret_valid", {31'd0, ret_valid}, 32'd1);
        check("ret_pc", ret_pc, r.pc);
      end else begin
        check("ret_valid", {31'd0, ret_valid}, 32'd0);
      end
    end
  end

  initial begin
    logic [5:0]  req;
    logic [15:0] addr;
    logic [10:0] lo, s0, s1, s2;
    int op;

    rst_n = 1'b0;
    {call, ret, push, pop, mem_write, mem_read} = '0;
    address = '0; write_data = '0; return_pc = '0;
    #12;
    check("reset_sp", {21'd0, sp}, 32'h7FF);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_ret_valid", {31'd0, ret_valid}, 32'd0);
    check("reset_read_data", {16'd0, read_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_sp = 11'h7FF;
    mon_en = 1'b1;

    // Store/load round trip, including an aliased upper address.
    issue(Q_WR, 16'h0010, 16'hBEEF, 32'd0);
    issue(Q_RD, 16'h0010, 16'h0000, 32'd0);
    issue(Q_RD, 16'hF810, 16'h0000, 32'd0);
    issue(6'd0, 16'h0000, 16'h0000, 32'd0);

    issue(Q_PUSH, 16'h0000, 16'h1234, 32'd0);
    issue(Q_PUSH, 16'h0000, 16'h5678, 32'd0);
    issue(Q_POP,  16'h0000, 16'h0000, 32'd0);
    issue(Q_POP,  16'h0000, 16'h0000, 32'd0);

    issue(Q_CALL, 16'h0000, 16'h0000, 32'hAABB_CCDD);
    issue(Q_RET,  16'h0000, 16'h0000, 32'd0);
    issue(6'd0,   16'h0000, 16'h0000, 32'd0);

    // Stack pointer wrap in both directions, plus push beating mem_read.
    issue(Q_WR, 16'h0000, 16'h0A0A, 32'd0);
    issue(Q_POP, 16'h0000, 16'h0000, 32'd0);
    issue(Q_PUSH | Q_RD, 16'h0010, 16'hC0DE, 32'd0);
    issue(Q_POP, 16'h0000, 16'h0000, 32'd0);
    issue(Q_PUSH, 16'h0000, 16'h1111, 32'd0);
    issue(6'd0, 16'h0000, 16'h0000, 32'd0);

    // Reset dropped while the second call word is pending.
    s0 = m_sp;
    @(posedge clk); #1;
    call = 1'b1; return_pc = 32'h1357_9BDF;
    cyc_q.push_back('{cyc, 1'b1, m_sp});
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_sp", {21'd0, sp}, 32'h7FF);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_ret_valid", {31'd0, ret_valid}, 32'd0);
    check("abort_read_data", {16'd0, read_data}, 32'd0);
    @(posedge clk); #1;
    check("abort_hold_stall", {31'd0, stall}, 32'd0);
    check("abort_hold_sp", {21'd0, sp}, 32'h7FF);
    call = 1'b0;
    rst_n = 1'b1;
    m_mem[s0] = 16'h1357; m_known[s0] = 1'b1;
    m_sp = 11'h7FF;
    exp_rd = '0;
    cyc_q.delete(); rd_q.delete(); ret_q.delete();
    mon_en = 1'b1;
    issue(Q_RD, {5'd0, s0}, 16'h0000, 32'd0);
    issue(6'd0, 16'h0000, 16'h0000, 32'd0);

    // Random request mixes; reads are steered to words the model knows.
    for (int it = 0; it < 400; it++) begin
      for (int b = 0; b < 6; b++) req[b] = ($urandom_range(0, 3) == 0);
      lo = $urandom_range(0, 1) ? 11'($urandom_range(0, 31))
                                : 11'(11'h7E0 + 11'($urandom_range(0, 31)));
      addr = {5'($urandom), lo};
      s1 = m_sp + 11'd1;
      s2 = m_sp + 11'd2;
      for (int t = 0; t < 6; t++) begin
        op = top_req(req);
        if (op == 4 && !(m_known[s1] && m_known[s2])) req[4] = 1'b0;
        else if (op == 2 && !m_known[s1]) req[2] = 1'b0;
        else if (op == 0 && !m_known[lo]) req[0] = 1'b0;
      end
      issue(req, addr, 16'($urandom), $urandom);
    end

    repeat (4) issue(6'd0, 16'h0000, 16'h0000, 32'd0);
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, word-address width of the data memory (2^ADDR_W 16-bit words).
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_read  input  1  load request.
REQ-006 SHALL have port mem_write  input  1  store request.
REQ-007 SHALL have port push  input  1  push write_data onto stack.
REQ-008 SHALL have port pop  input  1  pop stack into read_data.
REQ-009 SHALL have port call  input  1  push return_pc (two words).
REQ-010 SHALL have port ret  input  1  pop two words into ret_pc.
REQ-011 SHALL have port address  input  DATA_W  load/store address, the ALU result from Execute; only bits [ADDR_W-1:0] used.
REQ-012 SHALL have port write_data  input  DATA_W  store/push data (second register operand).
REQ-013 SHALL have port return_pc  input  32  PC saved by call.
REQ-014 SHALL have port read_data  output  DATA_W  registered load/pop result.
REQ-015 SHALL have port ret_pc  output  32  registered return address.
REQ-016 SHALL have port ret_valid  output  1  one-cycle pulse, ret_pc valid.
REQ-017 SHALL have port stall  output  1  upstream must hold its request and not issue a new one.
REQ-018 SHALL have port sp  output  ADDR_W  current stack pointer.

Function
REQ-019 Stack SHALL be full-descending, sp addressing the next free word: push writes M[sp] then sp-1; pop reads M[sp+1] then sp+1.
REQ-020 sp arithmetic SHALL be modulo 2^ADDR_W; push at sp=0 wraps to all-ones, pop at all-ones wraps to 0, no error flag.
REQ-021 Simultaneous requests SHALL resolve by priority call > ret > push > pop > mem_write > mem_read; lower requests that cycle are dropped.
REQ-022 mem_write SHALL write write_data to M[address[ADDR_W-1:0]] on the request edge.
REQ-023 mem_read and pop SHALL present data on read_data one cycle after the request edge; read_data SHALL hold its value until the next read/pop.
REQ-024 FSM states SHALL be IDLE, CALL_LO, RET_HI, RET_DONE.
REQ-025 call in IDLE SHALL write return_pc[31:16] to M[sp], sp-1, go to CALL_LO; stall=1 combinationally in that request cycle.
REQ-026 CALL_LO SHALL write latched return_pc[15:0] to M[sp], sp-1, return to IDLE; stall=0 in CALL_LO.
REQ-027 ret in IDLE SHALL read M[sp+1] as ret_pc[15:0], sp+1, go to RET_HI; stall=1 in request cycle and in RET_HI.
REQ-028 RET_HI SHALL read M[sp+1] as ret_pc[31:16], sp+1, go to RET_DONE.
REQ-029 RET_DONE SHALL assert ret_valid for exactly one cycle with complete ret_pc, stall=0, and return to IDLE; all request inputs SHALL be ignored in RET_DONE.
REQ-030 All request inputs SHALL be ignored in CALL_LO and RET_HI.
REQ-031 A store and a load to the same address in consecutive cycles SHALL return the newly stored value.

Reset
REQ-032 While rst_n=0: sp=2^ADDR_W-1, read_data=0, ret_pc=0, ret_valid=0, stall=0, state=IDLE; memory contents undefined/not cleared.
REQ-033 Reset asserted mid-call or mid-ret SHALL abort immediately to IDLE with REQ-032 values; partially written words remain.

Structure
REQ-034 FSM state enum and the sp reset constant SHALL live in the shared processor package.
REQ-035 Storage SHALL be one sub-module, data_memory: single-port, synchronous write, registered read, 2^ADDR_W x DATA_W.
REQ-036 memory_stage SHALL contain only FSM, sp register, request arbitration, address mux and ret_pc assembly.

Verification (ADDR_W=11)
REQ-037 Reset -> sp=0x7FF, stall=0, ret_valid=0, read_data=0.
REQ-038 mem_write addr=0x0010 data=0xBEEF, next cycle mem_read addr=0x0010 -> read_data=0xBEEF one cycle later; addr=0xF810 aliases the same word.
REQ-039 push 0x1234, push 0x5678, pop, pop -> read_data 0x5678 then 0x1234; sp 0x7FF->0x7FD->0x7FF.
REQ-040 call return_pc=0xAABB_CCDD then ret -> stall pattern 1,0 for call, 1,1,0 for ret; ret_valid pulse with ret_pc=0xAABBCCDD; sp back to 0x7FF.
REQ-041 push and mem_read asserted together at sp=0x000 -> only push executes, M[0x000]=write_data, sp wraps to 0x7FF.
REQ-042 rst_n dropped in CALL_LO -> state IDLE, sp=0x7FF, stall=0 asynchronously, no ret_valid.
